// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extender pipeline.
//   MODE_W  : width of the extension-mode field
//   mode_e  : extension modes (values 6 and 7 are reserved)
//   occ_e   : occupancy of the OUT/SKID register pair
package imm_ext_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_SEXT  = 3'd0,
    MODE_ZEXT  = 3'd1,
    MODE_LUI   = 3'd2,
    MODE_BOFF  = 3'd3,
    MODE_SEXT8 = 3'd4,
    MODE_ZEXT8 = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Valid/ready bundle between decode and the immediate extender.
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : extender side (drives in_ready, out_*)
interface imm_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 4
);
  import imm_ext_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [MODE_W-1:0] in_mode;
  logic [IN_W-1:0]   in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  modport master (
    output in_valid, in_mode, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );

endinterface

// File: rtl/imm_ext_core.sv
// Combinational extension unit: (mode, data) -> (ext, err).
//   mode : extension mode, see imm_ext_pkg::mode_e
//   data : raw immediate, IN_W bits
//   ext  : extended result, OUT_W bits (0 for reserved modes)
//   err  : high for reserved modes
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [IN_W-1:0]   data,
  output logic [OUT_W-1:0]  ext,
  output logic              err
);

  localparam int H = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;

  assign sext = {{H{data[IN_W-1]}}, data};

  always_comb begin
    ext = '0;
    err = 1'b0;
    case (mode)
      MODE_SEXT:  ext = sext;
      MODE_ZEXT:  ext = {{H{1'b0}}, data};
      MODE_LUI:   ext = {data, {H{1'b0}}};
      // branch offset: word-scaled, the two MSBs of the sign extension fall off
      MODE_BOFF:  ext = {sext[OUT_W-3:0], 2'b00};
      MODE_SEXT8: ext = {{(OUT_W-8){data[7]}}, data[7:0]};
      MODE_ZEXT8: ext = {{(OUT_W-8){1'b0}}, data[7:0]};
      default:    err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Multi-mode immediate extender with a 2-entry (OUT + SKID) valid/ready pipe.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset; clears all output registers
//   flush : drops held items and the item offered in the same cycle
//   bus   : imm_ext_pipe_if slave port (in_* / out_* handshake)
// Extension happens at the input; only extended values are stored.
// in_ready depends only on registered occupancy, flush and rst_n.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  imm_ext_pipe_if.slave  bus
);

  occ_e             state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_err_q, out_err_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_err_q, skid_err_d;

  logic [OUT_W-1:0] ext_data;
  logic             ext_err;
  logic             in_ready;
  logic             accept;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .mode (bus.in_mode),
    .data (bus.in_data),
    .ext  (ext_data),
    .err  (ext_err)
  );

  assign in_ready = rst_n & (state_q != ST_FULL) & ~flush;
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_err_d   = out_err_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    skid_err_d  = skid_err_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_data_d = ext_data;
            out_tag_d  = bus.in_tag;
            out_err_d  = ext_err;
            state_d    = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && bus.out_ready) begin
            out_data_d = ext_data;
            out_tag_d  = bus.in_tag;
            out_err_d  = ext_err;
          end else if (bus.out_ready) begin
            state_d = ST_EMPTY;
          end else if (accept) begin
            skid_data_d = ext_data;
            skid_tag_d  = bus.in_tag;
            skid_err_d  = ext_err;
            state_d     = ST_FULL;
          end
        end
        ST_FULL: begin
          if (bus.out_ready) begin
            out_data_d = skid_data_q;
            out_tag_d  = skid_tag_q;
            out_err_d  = skid_err_q;
            state_d    = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_err_q   <= out_err_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
      skid_err_q  <= skid_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_err   = out_err_q;

endmodule
